omem_write_buffer: RTL and testbench

OMEM_WRITE_BUFFER -- requirements
Module: omem_write_buffer

---
 rtl/omem_write_buffer_pkg.sv | 18 +
 rtl/omem_write_buffer_sync_fifo.sv | 56 +++++
 rtl/omem_write_buffer.sv | 112 +++++++++++
 tb/tb_omem_write_buffer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/omem_write_buffer_pkg.sv
// Shared definitions for the OMEM write buffer: bus widths, FSM state encoding
// and the occupancy-counter width helper.
package omem_write_buffer_pkg;

  localparam int WB_BUS_W         = 32;
  localparam int WB_WIDTH_DEFAULT = WB_BUS_W;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } wbState_t;

  // The level counter must hold DEPTH itself, hence one bit more than the pointers.
  function automatic int levelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/omem_write_buffer_sync_fifo.sv
// Synchronous FIFO holding buffered {address, data} words; the caller decides
// which pushes are accepted, so push and pop here are always honoured.
module sync_fifo
  import omem_write_buffer_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic [WIDTH-1:0]              i_data,
  output logic [WIDTH-1:0]              o_head,
  output logic [levelWidth(DEPTH)-1:0]  o_level,
  output logic                          o_empty,
  output logic                          o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = levelWidth(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [LVL_W-1:0] r_level;

  always_ff @(posedge i_clock) begin
    if (i_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (i_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_level = r_level;
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LVL_W'(DEPTH));

endmodule

// File: rtl/omem_write_buffer.sv
// Buffers vector-processor OMEM writes in a FIFO and drains them in order as
// Wishbone single writes; dropped writes raise a sticky overflow flag.
module omem_write_buffer
  import omem_write_buffer_pkg::*;
#(
  parameter int WB_WIDTH = WB_WIDTH_DEFAULT,
  parameter int DEPTH    = 8
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iOMEM_WE,
  input  logic [WB_WIDTH-1:0]           iOMEM_ADDR,
  input  logic [WB_WIDTH-1:0]           iOMEM_DATA,
  input  logic                          iClearOverflow,
  output logic                          WB_CYC_O,
  output logic                          WB_STB_O,
  output logic                          WB_WE_O,
  output logic [WB_WIDTH-1:0]           WB_ADR_O,
  output logic [WB_WIDTH-1:0]           WB_DAT_O,
  input  logic                          WB_ACK_I,
  output logic                          oEmpty,
  output logic                          oFull,
  output logic [levelWidth(DEPTH)-1:0]  oLevel,
  output logic                          oOverflow
);

  localparam int LVL_W = levelWidth(DEPTH);

  wbState_t              r_state;
  logic                  r_cyc;
  logic                  r_stb;
  logic                  r_we;
  logic                  r_overflow;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_full;
  logic                  w_empty;
  logic [LVL_W-1:0]      w_level;
  logic [2*WB_WIDTH-1:0] w_head;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_pop  = r_stb & WB_ACK_I;
  assign w_push = iOMEM_WE & (~w_full | w_pop);
  assign w_drop = iOMEM_WE & w_full & ~w_pop;

  sync_fifo #(
    .WIDTH (2*WB_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clock (Clock),
    .i_reset (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({iOMEM_ADDR, iOMEM_DATA}),
    .o_head  (w_head),
    .o_level (w_level),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // The FSM looks at the registered level, so a write never bypasses the FIFO.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop)              r_overflow <= 1'b1;
      else if (iClearOverflow) r_overflow <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_level != '0) begin
            r_state <= BUS;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
          end
        end
        BUS: begin
          if (WB_ACK_I && !(w_level > LVL_W'(1) || iOMEM_WE)) begin
            r_state <= IDLE;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign WB_CYC_O  = r_cyc;
  assign WB_STB_O  = r_stb;
  assign WB_WE_O   = r_we;
  assign WB_ADR_O  = r_stb ? w_head[2*WB_WIDTH-1:WB_WIDTH] : '0;
  assign WB_DAT_O  = r_stb ? w_head[WB_WIDTH-1:0] : '0;
  assign oEmpty    = w_empty;
  assign oFull     = w_full;
  assign oLevel    = w_level;
  assign oOverflow = r_overflow;

endmodule

// File: tb/tb_omem_write_buffer.sv
// Self-checking bench for omem_write_buffer: directed scenarios plus a random
// stream, all judged against a queue-based model of the buffered writes.
module tb_omem_write_buffer;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int LW = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iOMEM_WE;
  logic [W-1:0]  iOMEM_ADDR;
  logic [W-1:0]  iOMEM_DATA;
  logic          iClearOverflow;
  logic          WB_CYC_O;
  logic          WB_STB_O;
  logic          WB_WE_O;
  logic [W-1:0]  WB_ADR_O;
  logic [W-1:0]  WB_DAT_O;
  logic          WB_ACK_I;
  logic          oEmpty;
  logic          oFull;
  logic [LW-1:0] oLevel;
  logic          oOverflow;

  int vectors     = 0;
  int miscompares = 0;
  int writeCount  = 0;

  logic [2*W-1:0] refQ [$];
  logic           ovfModel = 1'b0;
  logic [W-1:0]   lastData = '0;

  omem_write_buffer #(.WB_WIDTH(W), .DEPTH(D)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .iOMEM_WE       (iOMEM_WE),
    .iOMEM_ADDR     (iOMEM_ADDR),
    .iOMEM_DATA     (iOMEM_DATA),
    .iClearOverflow (iClearOverflow),
    .WB_CYC_O       (WB_CYC_O),
    .WB_STB_O       (WB_STB_O),
    .WB_WE_O        (WB_WE_O),
    .WB_ADR_O       (WB_ADR_O),
    .WB_DAT_O       (WB_DAT_O),
    .WB_ACK_I       (WB_ACK_I),
    .oEmpty         (oEmpty),
    .oFull          (oFull),
    .oLevel         (oLevel),
    .oOverflow      (oOverflow)
  );

  always #5 Clock = ~Clock;

  // Reference model: a queue of accepted writes; each bus handshake must
  // retire the oldest one, and a write arriving with D entries held and no
  // handshake in that cycle is dropped.
  always @(negedge Clock) begin
    logic dropNow;
    logic [2*W-1:0] exp;
    dropNow = 1'b0;
    if (Reset) begin
      refQ.delete();
      ovfModel = 1'b0;
    end else begin
      vectors++;
      if (WB_CYC_O !== WB_STB_O || WB_WE_O !== WB_STB_O) begin
        miscompares++;
        $display("[TB] FAIL bus_ctrl: cyc=%b stb=%b we=%b, want all equal", WB_CYC_O, WB_STB_O, WB_WE_O);
      end
      if (WB_STB_O === 1'b1 && WB_ACK_I === 1'b1) begin
        vectors++;
        writeCount++;
        lastData = WB_DAT_O;
        if (refQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL bus_write: got %h/%h, want no write", WB_ADR_O, WB_DAT_O);
        end else begin
          exp = refQ.pop_front();
          if ({WB_ADR_O, WB_DAT_O} !== exp) begin
            miscompares++;
            $display("[TB] FAIL bus_write: got %h/%h, want %h/%h", WB_ADR_O, WB_DAT_O, exp[2*W-1:W], exp[W-1:0]);
          end
        end
      end
      if (iOMEM_WE) begin
        if (refQ.size() < D) refQ.push_back({iOMEM_ADDR, iOMEM_DATA});
        else dropNow = 1'b1;
      end
      if (dropNow) ovfModel = 1'b1;
      else if (iClearOverflow) ovfModel = 1'b0;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({WB_CYC_O, WB_STB_O, WB_WE_O, oEmpty, oFull, oOverflow} !== 6'b000100) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got cyc/stb/we/empty/full/ovf=%b, want 000100",
               {WB_CYC_O, WB_STB_O, WB_WE_O, oEmpty, oFull, oOverflow});
    end
    vectors++;
    if (oLevel !== 0 || WB_ADR_O !== 0 || WB_DAT_O !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got level=%0d adr=%h dat=%h, want 0/0/0", oLevel, WB_ADR_O, WB_DAT_O);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    int base;
    logic expStb;
    base = writeCount;
    iOMEM_WE = 1'b1; iOMEM_ADDR = 32'h10; iOMEM_DATA = 32'hAABBCCDD;
    tick();
    iOMEM_WE = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      expStb = (k >= 1 && k <= 3);
      WB_ACK_I = (k == 3);
      vectors++;
      if (WB_STB_O !== expStb) begin
        miscompares++;
        $display("[TB] FAIL single_stb cycle %0d: got %b, want %b", k, WB_STB_O, expStb);
      end
      if (expStb) begin
        vectors++;
        if (WB_ADR_O !== 32'h10 || WB_DAT_O !== 32'hAABBCCDD) begin
          miscompares++;
          $display("[TB] FAIL single_bus cycle %0d: got %h/%h, want 00000010/aabbccdd", k, WB_ADR_O, WB_DAT_O);
        end
      end
      if (k < 4) tick();
    end
    WB_ACK_I = 1'b0;
    vectors++;
    if (oEmpty !== 1'b1 || writeCount - base != 1) begin
      miscompares++;
      $display("[TB] FAIL single_end: got empty=%b writes=%0d, want 1/1", oEmpty, writeCount - base);
    end
  endtask

  task automatic test_back_to_back();
    logic expStb;
    WB_ACK_I = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (k < 3) begin
        iOMEM_WE = 1'b1; iOMEM_ADDR = W'(k); iOMEM_DATA = $urandom;
      end else begin
        iOMEM_WE = 1'b0;
      end
      expStb = (k >= 2 && k <= 4);
      vectors++;
      if (WB_STB_O !== expStb) begin
        miscompares++;
        $display("[TB] FAIL b2b_stb cycle %0d: got %b, want %b", k, WB_STB_O, expStb);
      end
      if (expStb) begin
        vectors++;
        if (WB_ADR_O !== W'(k - 2)) begin
          miscompares++;
          $display("[TB] FAIL b2b_adr cycle %0d: got %h, want %h", k, WB_ADR_O, W'(k - 2));
        end
      end
      tick();
    end
    WB_ACK_I = 1'b0;
    vectors++;
    if (oEmpty !== 1'b1 || refQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_end: got empty=%b model=%0d, want 1/0", oEmpty, refQ.size());
    end
  endtask

  task automatic test_overflow();
    int base;
    base = writeCount;
    WB_ACK_I = 1'b0;
    for (int i = 0; i < 9; i++) begin
      iOMEM_WE = 1'b1; iOMEM_ADDR = W'(32'h100 + i); iOMEM_DATA = $urandom;
      iClearOverflow = (i == 8);
      tick();
      if (i == 7) begin
        vectors++;
        if (oFull !== 1'b1 || oLevel !== LW'(8) || oOverflow !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL ovf_full: got full=%b level=%0d ovf=%b, want 1/8/0", oFull, oLevel, oOverflow);
        end
      end
    end
    iOMEM_WE = 1'b0; iClearOverflow = 1'b0;
    vectors++;
    if (oOverflow !== 1'b1 || ovfModel !== 1'b1 || oLevel !== LW'(8)) begin
      miscompares++;
      $display("[TB] FAIL ovf_drop: got ovf=%b level=%0d, want 1/8", oOverflow, oLevel);
    end
    WB_ACK_I = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    WB_ACK_I = 1'b0;
    vectors++;
    if (writeCount - base != 8 || oEmpty !== 1'b1 || oOverflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_drain: got writes=%0d empty=%b ovf=%b, want 8/1/1", writeCount - base, oEmpty, oOverflow);
    end
    iClearOverflow = 1'b1;
    tick();
    iClearOverflow = 1'b0;
    vectors++;
    if (oOverflow !== 1'b0 || oOverflow !== ovfModel) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear: got %b, want 0", oOverflow);
    end
  endtask

  task automatic test_full_push_pop();
    WB_ACK_I = 1'b0;
    for (int i = 0; i < D; i++) begin
      iOMEM_WE = 1'b1; iOMEM_ADDR = W'(32'h200 + i); iOMEM_DATA = $urandom;
      tick();
    end
    iOMEM_WE = 1'b1; iOMEM_ADDR = 32'h299; iOMEM_DATA = 32'h99;
    WB_ACK_I = 1'b1;
    tick();
    iOMEM_WE = 1'b0; WB_ACK_I = 1'b0;
    vectors++;
    if (oLevel !== LW'(8) || oFull !== 1'b1 || oOverflow !== 1'b0 || refQ.size() != 8) begin
      miscompares++;
      $display("[TB] FAIL fullpp_level: got level=%0d full=%b ovf=%b, want 8/1/0", oLevel, oFull, oOverflow);
    end
    WB_ACK_I = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    WB_ACK_I = 1'b0;
    vectors++;
    if (lastData !== 32'h99 || oEmpty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fullpp_last: got last=%h empty=%b, want 00000099/1", lastData, oEmpty);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    WB_ACK_I = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iOMEM_WE = 1'b1; iOMEM_ADDR = $urandom; iOMEM_DATA = $urandom;
      tick();
    end
    iOMEM_WE = 1'b0;
    vectors++;
    if (WB_STB_O !== 1'b1 || oLevel !== LW'(4)) begin
      miscompares++;
      $display("[TB] FAIL rstmid_pre: got stb=%b level=%0d, want 1/4", WB_STB_O, oLevel);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    base = writeCount;
    vectors++;
    if (WB_CYC_O !== 1'b0 || WB_STB_O !== 1'b0 || oLevel !== 0 || oEmpty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_post: got cyc=%b stb=%b level=%0d empty=%b, want 0/0/0/1",
               WB_CYC_O, WB_STB_O, oLevel, oEmpty);
    end
    WB_ACK_I = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    WB_ACK_I = 1'b0;
    vectors++;
    if (writeCount != base || WB_STB_O !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_quiet: got writes=%0d stb=%b, want 0/0", writeCount - base, WB_STB_O);
    end
  endtask

  task automatic test_wrap();
    int base;
    int pushed;
    int ackDelay;
    int c;
    base = writeCount;
    pushed = 0;
    ackDelay = $urandom_range(0, 3);
    for (c = 0; c < 600 && !(pushed == 20 && writeCount - base == 20); c++) begin
      if (WB_STB_O === 1'b1) begin
        if (ackDelay == 0) begin
          WB_ACK_I = 1'b1;
          ackDelay = $urandom_range(0, 3);
        end else begin
          WB_ACK_I = 1'b0;
          ackDelay--;
        end
      end else begin
        WB_ACK_I = 1'b0;
      end
      if (pushed < 20 && refQ.size() < D && $urandom_range(0, 3) != 0) begin
        iOMEM_WE = 1'b1; iOMEM_ADDR = W'(32'h300 + pushed); iOMEM_DATA = $urandom;
        pushed++;
      end else begin
        iOMEM_WE = 1'b0;
      end
      tick();
    end
    iOMEM_WE = 1'b0; WB_ACK_I = 1'b0;
    vectors++;
    if (c >= 600) begin
      miscompares++;
      $display("[TB] FAIL wrap_timeout: got pushed=%0d writes=%0d, want 20/20", pushed, writeCount - base);
    end
    vectors++;
    if (writeCount - base != 20 || oOverflow !== 1'b0 || refQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL wrap_end: got writes=%0d ovf=%b left=%0d, want 20/0/0",
               writeCount - base, oOverflow, refQ.size());
    end
  endtask

  initial begin
    Reset = 1'b1;
    iOMEM_WE = 1'b0;
    iOMEM_ADDR = '0;
    iOMEM_DATA = '0;
    iClearOverflow = 1'b0;
    WB_ACK_I = 1'b0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_wrap();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
